// File: rtl/final_video_pkg.sv
// Shared definitions for the final video path: layer codes, PROM selects and
// the timing bundle carried alongside the colour pipeline.
package final_video_pkg;

   localparam logic [1:0] LAYER_SPR = 2'b00;
   localparam logic [1:0] LAYER_FG  = 2'b01;
   localparam logic [1:0] LAYER_BG  = 2'b10;
   localparam logic [1:0] LAYER_TX  = 2'b11;

   localparam logic [1:0] PROM_R = 2'd0;
   localparam logic [1:0] PROM_G = 2'd1;
   localparam logic [1:0] PROM_B = 2'd2;

   typedef struct packed {
      logic hblank;
      logic vblank;
      logic hs;
      logic vs;
   } timing_t;

   // Blanking asserted, syncs idle: the safe state after reset.
   localparam timing_t TIMING_RST = '{hblank: 1'b1, vblank: 1'b1, hs: 1'b0, vs: 1'b0};

   function automatic logic [7:0] layer_mux(input logic [1:0] sel,
                                            input logic [7:0] spr,
                                            input logic [7:0] fg,
                                            input logic [7:0] bg,
                                            input logic [7:0] tx);
      logic [7:0] pix;
      case (sel)
         LAYER_SPR: pix = spr;
         LAYER_FG:  pix = fg;
         LAYER_BG:  pix = bg;
         default:   pix = tx;
      endcase
      return pix;
   endfunction

endpackage

// File: rtl/color_prom_dpram.sv
// Single-clock colour PROM image: one write port for the ROM download, one
// enabled synchronous read port. A same-address collision returns the old data.
module color_prom_dpram #(
   parameter int AW = 10,
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // Both updates are non-blocking in one block, so the read sees the pre-write word.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/final_color_lut.sv
// Palette back-end: selects the winning layer pixel, looks it up in the R/G/B
// PROM images and emits registered colour aligned with the delayed timing.
module final_color_lut
   import final_video_pkg::*;
#(
   parameter int PAL_AW    = 10,
   parameter bit PIPE_SYNC = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ce_pix,
   input  logic [1:0]        layer_sel,
   input  logic [1:0]        colbank,
   input  logic [7:0]        spr_pix,
   input  logic [7:0]        fg_pix,
   input  logic [7:0]        bg_pix,
   input  logic [7:0]        tx_pix,
   input  logic              hblank_in,
   input  logic              vblank_in,
   input  logic              hs_in,
   input  logic              vs_in,
   input  logic              dn_wr,
   input  logic [1:0]        dn_sel,
   input  logic [PAL_AW-1:0] dn_addr,
   input  logic [3:0]        dn_data,
   input  logic              dn_active,
   output logic [3:0]        r,
   output logic [3:0]        g,
   output logic [3:0]        b,
   output logic              hblank,
   output logic              vblank,
   output logic              hs,
   output logic              vs
);

   localparam int FULL_AW = 10;

   timing_t            tim_in;
   timing_t            tim_s0;
   timing_t            tim_s1;
   timing_t            tim_q;
   logic [FULL_AW-1:0] addr_full;
   logic [PAL_AW-1:0]  addr_q;
   logic [3:0]         r_rd;
   logic [3:0]         g_rd;
   logic [3:0]         b_rd;
   logic               force_black;

   assign tim_in    = '{hblank: hblank_in, vblank: vblank_in, hs: hs_in, vs: vs_in};
   assign addr_full = {colbank, layer_mux(layer_sel, spr_pix, fg_pix, bg_pix, tx_pix)};
   // Blanking comes from the timing that travels with this pixel; download is live.
   assign force_black = tim_s1.hblank | tim_s1.vblank | dn_active;

   // Download port: dn_wr is a one-clk strobe, no handshake, taken regardless of ce_pix.
   color_prom_dpram #(.AW(PAL_AW), .DW(4)) u_prom_r (
      .clk   (clk),
      .we    (dn_wr && (dn_sel == PROM_R)),
      .waddr (dn_addr),
      .wdata (dn_data),
      .re    (ce_pix),
      .raddr (addr_q),
      .rdata (r_rd)
   );

   color_prom_dpram #(.AW(PAL_AW), .DW(4)) u_prom_g (
      .clk   (clk),
      .we    (dn_wr && (dn_sel == PROM_G)),
      .waddr (dn_addr),
      .wdata (dn_data),
      .re    (ce_pix),
      .raddr (addr_q),
      .rdata (g_rd)
   );

   color_prom_dpram #(.AW(PAL_AW), .DW(4)) u_prom_b (
      .clk   (clk),
      .we    (dn_wr && (dn_sel == PROM_B)),
      .waddr (dn_addr),
      .wdata (dn_data),
      .re    (ce_pix),
      .raddr (addr_q),
      .rdata (b_rd)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q <= '0;
         tim_s0 <= TIMING_RST;
         tim_s1 <= TIMING_RST;
         tim_q  <= TIMING_RST;
         r      <= 4'h0;
         g      <= 4'h0;
         b      <= 4'h0;
      end else if (ce_pix) begin
         addr_q <= PAL_AW'(addr_full);
         tim_s0 <= tim_in;
         tim_s1 <= tim_s0;
         tim_q  <= tim_s1;
         if (force_black) begin
            r <= 4'h0;
            g <= 4'h0;
            b <= 4'h0;
         end else begin
            r <= r_rd;
            g <= g_rd;
            b <= b_rd;
         end
      end
   end

   assign hblank = PIPE_SYNC ? tim_q.hblank : hblank_in;
   assign vblank = PIPE_SYNC ? tim_q.vblank : vblank_in;
   assign hs     = PIPE_SYNC ? tim_q.hs     : hs_in;
   assign vs     = PIPE_SYNC ? tim_q.vs     : vs_in;

endmodule
